div_unit: RTL and testbench
===========================

# div_unit

Iterative 32-bit integer divider for the multi-cycle datapath: the division counterpart to the ALU's MUL/UMUL/SMUL paths. It is started by the controller FSM, runs one restoring step per cycle, and returns quotient and remainder with ARM-style NZCV flags. The controller stalls on `busy` and writes back on `done`, using `Quotient` in place of `Result` and `Remainder` in place of `ResultHi`.

## Interface
- No parameters; width fixed at 32.
- `clk`  in  1  rising-edge clock
- `reset`  in  1  asynchronous, active-low reset
- `start`  in  1  request; sampled only in IDLE or DONE
- `is_signed`  in  1  1 = SDIV, 0 = UDIV; sampled with `start`
- `a`  in  32  dividend; sampled with `start`
- `b`  in  32  divisor; sampled with `start`
- `busy`  out  1  high in CALC and FIX
- `done`  out  1  one-cycle pulse; results valid from this cycle until the next accepted `start`
- `Quotient`  out  32  quotient, truncated toward zero
- `Remainder`  out  32  remainder; its sign follows the dividend
- `DivFlags`  out  4  {N, Z, C, V}
- `DivZero`  out  1  set with `done` when `b` = 0; holds until the next accepted `start`

## Operation
- States: IDLE, CALC, FIX, DONE.
  - IDLE/DONE + `start`, `b` ≠ 0: latch |a| and |b| (magnitudes only if signed), latch sign bits, clear the partial remainder, load counter 31, go to CALC.
  - IDLE/DONE + `start`, `b` = 0: go straight to DONE.
  - DONE without `start`: go to IDLE.
- CALC: each cycle, shift {rem, quo} left by 1 and form trial = rem − |b| (33-bit).
  - If trial is non-negative: rem = trial and quotient LSB = 1.
  - Otherwise: restore rem and set quotient LSB = 0.
  - Decrement the counter. Leave after the step at counter 0, giving 32 steps in total.
- FIX:
  - Negate the quotient if the operand signs differ (signed mode only).
  - Negate the remainder if the dividend was negative (signed mode only).
  - Go to DONE.
- Divide by zero (ARM semantics): `Quotient` = 0, `Remainder` = a, `DivZero` = 1.
- Signed overflow, a = 0x80000000 and b = 0xFFFFFFFF: `Quotient` = 0x80000000, `Remainder` = 0, V = 1. The natural datapath produces these values; no special case is needed beyond the V detect.
- Flags:
  - N = Quotient[31]; Z = (Quotient == 0); C = 0.
  - V = 1 only for the signed-overflow case above.
- `start` while `busy` is ignored; no queuing.
- `a`, `b` and `is_signed` may change after acceptance without effect.

## Timing
- `start` accepted at edge 0. CALC occupies the cycles after edges 0..31, FIX the cycle after edge 32, and DONE the cycle after edge 33.
  - `done` is high for exactly one cycle, 34 cycles after acceptance.
- Divide-by-zero path: `done` in the cycle after edge 0 (latency 1).
- Back-to-back: `start` in the DONE cycle is accepted. The outputs then hold the old values until the new run's DONE.
- `Quotient`, `Remainder`, `DivFlags` and `DivZero` are registered and update only on entry to DONE.
- Reset value (asynchronous, whenever `reset` is 0): state IDLE, all outputs 0, counter 0.
- Reset mid-operation: abort immediately. No `done` is issued and outputs return to 0.

## Configuration
- `DIV_SIGNED_EN`
  - Defined: `is_signed` is honoured and the magnitude, FIX negation and V-detect logic is present.
  - Undefined: `is_signed` is ignored and treated as 0. FIX does no negation and V is constantly 0. FIX stays as a one-cycle pass-through so latency is unchanged.

## Structure
- Shared package `alu_pkg` holds:
  - the state enum `div_state_t` (IDLE, CALC, FIX, DONE);
  - the flag bit-index constants `FLAG_N`, `FLAG_Z`, `FLAG_C`, `FLAG_V`, shared with the ALU;
  - `DIV_STEPS` = 32.
- One sub-module, `div_step`: a purely combinational single restoring iteration.
  - Inputs: rem, quo, divisor.
  - Outputs: next rem, next quo.
  - It is instantiated once and reused each cycle by the FSM.

## Test plan
- Unsigned 100 / 7 (`is_signed` = 0) → `Quotient` = 14, `Remainder` = 2, flags 0000, `done` exactly 34 cycles after `start`, `busy` high 33 cycles.
- Signed −7 / 2 (a = 0xFFFFFFF9) → `Quotient` = 0xFFFFFFFD, `Remainder` = 0xFFFFFFFF, N = 1. Same operands unsigned → `Quotient` = 0x7FFFFFFC, `Remainder` = 1.
- Signed 0x80000000 / 0xFFFFFFFF → `Quotient` = 0x80000000, `Remainder` = 0, flags {1,0,0,1}.
- 5 / 0 → `done` one cycle after `start`, `Quotient` = 0, `Remainder` = 5, `DivZero` = 1, Z = 1.
- Second `start` pulsed at cycle 10 of a run → ignored; the first result is intact. `start` in the DONE cycle → the new run completes 34 cycles later.
- `reset` driven low at cycle 20 of a run → all outputs 0 immediately, no `done`. After release, 12 / 4 → `Quotient` = 3, `Remainder` = 0.

Source files
------------

// File: rtl/alu_pkg.sv
// alu_pkg: shared datapath types and constants (divider FSM states, NZCV flag indices, divide step count)
package alu_pkg;

   typedef enum logic [1:0] {
      IDLE,
      CALC,
      FIX,
      DONE
   } div_state_t;

   // Bit positions inside a {N, Z, C, V} flag nibble
   localparam int FLAG_N = 3;
   localparam int FLAG_Z = 2;
   localparam int FLAG_C = 1;
   localparam int FLAG_V = 0;

   localparam int DIV_STEPS = 32;

endpackage

// File: rtl/div_step.sv
// div_step: one combinational restoring-division iteration on {rem, quo}
module div_step (
   input  logic [31:0] i_rem,
   input  logic [31:0] i_quo,
   input  logic [31:0] i_div,
   output logic [31:0] o_rem,
   output logic [31:0] o_quo
);

   logic [32:0] w_shift;
   logic [32:0] w_trial;

   // rem < divisor always holds, so the 33-bit trial difference cannot wrap and bit 32 is its sign
   always_comb begin
      w_shift = {i_rem, i_quo[31]};
      w_trial = w_shift - {1'b0, i_div};
      o_rem   = w_trial[32] ? w_shift[31:0] : w_trial[31:0];
      o_quo   = {i_quo[30:0], ~w_trial[32]};
   end

endmodule

// File: rtl/div_unit.sv
// div_unit: iterative 32-bit restoring divider with NZCV flags; `DIV_SIGNED_EN enables SDIV support
module div_unit
   import alu_pkg::*;
(
   input  logic        clk,
   input  logic        reset,
   input  logic        start,
   input  logic        is_signed,
   input  logic [31:0] a,
   input  logic [31:0] b,
   output logic        busy,
   output logic        done,
   output logic [31:0] Quotient,
   output logic [31:0] Remainder,
   output logic [3:0]  DivFlags,
   output logic        DivZero
);

   div_state_t  r_state;
   logic [4:0]  r_cnt;
   logic [31:0] r_rem;
   logic [31:0] r_quo;
   logic [31:0] r_div;
   logic        r_neg_q;
   logic        r_neg_r;
   logic        r_ovf;

   logic [31:0] w_a_mag;
   logic [31:0] w_b_mag;
   logic [31:0] w_quo_fix;
   logic [31:0] w_rem_fix;
   logic [31:0] w_rem_nx;
   logic [31:0] w_quo_nx;
   logic        w_neg_q;
   logic        w_neg_r;
   logic        w_ovf;
   logic [3:0]  w_flags;

`ifdef DIV_SIGNED_EN
   // Signed operation divides magnitudes and restores the signs in FIX
   assign w_a_mag   = (is_signed && a[31]) ? -a : a;
   assign w_b_mag   = (is_signed && b[31]) ? -b : b;
   assign w_neg_q   = is_signed && (a[31] ^ b[31]);
   assign w_neg_r   = is_signed && a[31];
   assign w_ovf     = is_signed && (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
   assign w_quo_fix = r_neg_q ? -r_quo : r_quo;
   assign w_rem_fix = r_neg_r ? -r_rem : r_rem;
`else
   logic w_unused;
   assign w_unused  = is_signed;
   assign w_a_mag   = a;
   assign w_b_mag   = b;
   assign w_neg_q   = 1'b0;
   assign w_neg_r   = 1'b0;
   assign w_ovf     = 1'b0;
   assign w_quo_fix = r_quo;
   assign w_rem_fix = r_rem;
`endif

   div_step u_step (
      .i_rem (r_rem),
      .i_quo (r_quo),
      .i_div (r_div),
      .o_rem (w_rem_nx),
      .o_quo (w_quo_nx)
   );

   // Flags of the final (sign-corrected) quotient
   always_comb begin
      w_flags         = '0;
      w_flags[FLAG_N] = w_quo_fix[31];
      w_flags[FLAG_Z] = (w_quo_fix == '0);
      w_flags[FLAG_C] = 1'b0;
      w_flags[FLAG_V] = r_ovf;
   end

   // Control FSM with registered busy/done; results are written only on entry to DONE
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_state   <= IDLE;
         r_cnt     <= '0;
         r_rem     <= '0;
         r_quo     <= '0;
         r_div     <= '0;
         r_neg_q   <= 1'b0;
         r_neg_r   <= 1'b0;
         r_ovf     <= 1'b0;
         busy      <= 1'b0;
         done      <= 1'b0;
         Quotient  <= '0;
         Remainder <= '0;
         DivFlags  <= '0;
         DivZero   <= 1'b0;
      end else begin
         done <= 1'b0;
         unique case (r_state)
            IDLE, DONE: begin
               if (start && b == '0) begin
                  r_state   <= DONE;
                  done      <= 1'b1;
                  Quotient  <= '0;
                  Remainder <= a;
                  DivFlags  <= 4'b0100;
                  DivZero   <= 1'b1;
               end else if (start) begin
                  r_state <= CALC;
                  busy    <= 1'b1;
                  r_rem   <= '0;
                  r_quo   <= w_a_mag;
                  r_div   <= w_b_mag;
                  r_neg_q <= w_neg_q;
                  r_neg_r <= w_neg_r;
                  r_ovf   <= w_ovf;
                  r_cnt   <= 5'(DIV_STEPS - 1);
               end else begin
                  r_state <= IDLE;
               end
            end
            CALC: begin
               r_rem <= w_rem_nx;
               r_quo <= w_quo_nx;
               r_cnt <= r_cnt - 5'd1;
               if (r_cnt == '0) r_state <= FIX;
            end
            FIX: begin
               r_state   <= DONE;
               busy      <= 1'b0;
               done      <= 1'b1;
               Quotient  <= w_quo_fix;
               Remainder <= w_rem_fix;
               DivFlags  <= w_flags;
               DivZero   <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_div_unit.sv
// tb_div_unit: scoreboard bench for div_unit; expectations follow `DIV_SIGNED_EN
module tb_div_unit;

   logic        clk = 1'b0;
   logic        reset = 1'b0;
   logic        start = 1'b0;
   logic        is_signed = 1'b0;
   logic [31:0] a = '0;
   logic [31:0] b = '0;
   logic        busy;
   logic        done;
   logic [31:0] Quotient;
   logic [31:0] Remainder;
   logic [3:0]  DivFlags;
   logic        DivZero;

   typedef struct {
      logic [31:0] q;
      logic [31:0] r;
      logic [3:0]  f;
      logic        dz;
      int          lat;
      int          acc;
   } exp_t;

   exp_t sb[$];
   int   tests = 0;
   int   fails = 0;
   int   cyc = 0;
   int   bcnt = 0;

   div_unit dut (
      .clk       (clk),
      .reset     (reset),
      .start     (start),
      .is_signed (is_signed),
      .a         (a),
      .b         (b),
      .busy      (busy),
      .done      (done),
      .Quotient  (Quotient),
      .Remainder (Remainder),
      .DivFlags  (DivFlags),
      .DivZero   (DivZero)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) if (busy) bcnt <= bcnt + 1;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // Monitor: every done pulse pops the oldest expectation
   always @(negedge clk) begin
      if (reset && done) begin
         if (sb.size() == 0) begin
            chk("unexpected_done", 32'd1, 32'd0);
         end else begin
            exp_t e;
            e = sb.pop_front();
            chk("quotient", Quotient, e.q);
            chk("remainder", Remainder, e.r);
            chk("flags", {28'd0, DivFlags}, {28'd0, e.f});
            chk("divzero", {31'd0, DivZero}, {31'd0, e.dz});
            chk("latency", cyc - e.acc + 1, e.lat);
         end
      end
   end

   // Caller is at a negedge; drives a request, returns #1 after the accepting edge
   task automatic go(input logic push, input logic sg, input logic [31:0] ta, input logic [31:0] tb,
                     input logic [31:0] q, input logic [31:0] r, input logic [3:0] f,
                     input logic dz, input int lat);
      exp_t e;
      start = 1'b1;
      is_signed = sg;
      a = ta;
      b = tb;
      @(posedge clk);
      #1;
      start = 1'b0;
      a = $urandom;
      b = $urandom;
      is_signed = $urandom_range(0, 1);
      if (push) begin
         e.q = q;
         e.r = r;
         e.f = f;
         e.dz = dz;
         e.lat = lat;
         e.acc = cyc;
         sb.push_back(e);
      end
   endtask

   task automatic wait_done();
      int i;
      for (i = 0; i < 60; i++) begin
         @(negedge clk);
         if (done) break;
      end
      if (i == 60) chk("done_timeout", 32'd1, 32'd0);
   endtask

   initial begin
      #2;
      chk("reset_q", Quotient, 32'd0);
      chk("reset_r", Remainder, 32'd0);
      chk("reset_ctl", {25'd0, busy, done, DivZero, DivFlags}, 32'd0);
      repeat (2) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);

      bcnt = 0;
      go(1, 0, 32'd100, 32'd7, 32'd14, 32'd2, 4'b0000, 0, 34);
      wait_done();
      chk("busy_cycles", bcnt, 33);
      @(negedge clk);

`ifdef DIV_SIGNED_EN
      go(1, 1, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD, 32'hFFFFFFFF, 4'b1000, 0, 34);
`else
      go(1, 1, 32'hFFFFFFF9, 32'd2, 32'h7FFFFFFC, 32'd1, 4'b0000, 0, 34);
`endif
      wait_done();
      @(negedge clk);

      go(1, 0, 32'hFFFFFFF9, 32'd2, 32'h7FFFFFFC, 32'd1, 4'b0000, 0, 34);
      wait_done();
      @(negedge clk);

`ifdef DIV_SIGNED_EN
      go(1, 1, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 32'd0, 4'b1001, 0, 34);
`else
      go(1, 1, 32'h80000000, 32'hFFFFFFFF, 32'd0, 32'h80000000, 4'b0100, 0, 34);
`endif
      wait_done();
      @(negedge clk);

`ifdef DIV_SIGNED_EN
      go(1, 1, 32'd100, 32'hFFFFFFF9, 32'hFFFFFFF2, 32'd2, 4'b1000, 0, 34);
`else
      go(1, 1, 32'd100, 32'hFFFFFFF9, 32'd0, 32'd100, 4'b0100, 0, 34);
`endif
      wait_done();
      @(negedge clk);

      go(1, 0, 32'd7, 32'd9, 32'd0, 32'd7, 4'b0100, 0, 34);
      wait_done();
      @(negedge clk);

      go(1, 0, 32'd5, 32'd0, 32'd0, 32'd5, 4'b0100, 1, 1);
      wait_done();
      @(negedge clk);

      go(1, 0, 32'd1000, 32'd10, 32'd100, 32'd0, 4'b0000, 0, 34);
      repeat (9) @(negedge clk);
      start = 1'b1;
      a = 32'd9;
      b = 32'd3;
      @(negedge clk);
      start = 1'b0;
      wait_done();
      go(1, 0, 32'hFFFFFFFF, 32'h10, 32'h0FFFFFFF, 32'hF, 4'b0000, 0, 34);
      wait_done();
      @(negedge clk);

      go(0, 0, 32'd100, 32'd7, 32'd0, 32'd0, 4'b0000, 0, 0);
      repeat (20) @(negedge clk);
      #2 reset = 1'b0;
      #1;
      chk("abort_q", Quotient, 32'd0);
      chk("abort_r", Remainder, 32'd0);
      chk("abort_ctl", {25'd0, busy, done, DivZero, DivFlags}, 32'd0);
      @(negedge clk);
      reset = 1'b1;
      repeat (40) @(negedge clk);

      go(1, 0, 32'd12, 32'd4, 32'd3, 32'd0, 4'b0000, 0, 34);
      wait_done();
      repeat (3) @(negedge clk);
      chk("scoreboard_empty", sb.size(), 32'd0);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
